matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the 4x4 `matrix_multiplication` unit and its A/B operand RAMs. It accepts one command from a host, streams operand bytes into RAM A (row-major) and RAM B (column-major), and zero-fills the tail padding words. It then drives `start`, waits for `done`, clears it, and streams the result matrix back to the host.

## Interface
Parameters:
- `DWIDTH`, 8: element width
- `AWIDTH`, 15: operand RAM address width (depth 2^AWIDTH)
- `MAT_SIZE`, 4: matrix dimension N; N*N elements per matrix
- `TIMEOUT_CYCLES`, 4096: done-wait limit (used only with the watchdog)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in/out  1  start-of-job handshake
- `in_valid` / `in_ready`  in/out  1  operand stream handshake
- `in_data`  in  DWIDTH  operand bytes: N*N A bytes, then N*N B bytes
- `out_valid` / `out_ready`  out/in  1  result stream handshake
- `out_data`  out  DWIDTH  result bytes, row-major C[0][0]..C[N-1][N-1]
- `a_we`, `b_we`  out  1  operand RAM write enables
- `a_addr`, `b_addr`  out  AWIDTH  operand RAM addresses
- `a_wdata`, `b_wdata`  out  DWIDTH  operand RAM write data
- `res_addr`  out  AWIDTH  result RAM read address (1-cycle read latency)
- `res_rdata`  in  DWIDTH  result RAM read data
- `mm_start`  out  1  level start to the multiplier
- `mm_clear_done`  out  1  clear-done pulse
- `mm_done`  in  1  multiplier done
- `busy`  out  1  high in every state except IDLE
- `error`  out  1  sticky timeout flag (watchdog builds only)

## Operation
- States: IDLE, LOAD_A, LOAD_B, PAD, START, WAIT, CLEAR, RD_ADDR, RD_DATA.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, go to LOAD_A and zero the element counter `k`.
- LOAD_A: `in_ready`=1. Each accepted byte writes `a_we`=1, `a_addr`=k, `a_wdata`=`in_data`. After k=N*N-1, reset k and go to LOAD_B.
- LOAD_B: same as LOAD_A, but targets RAM B. After the last element, go to PAD.
- PAD: N cycles. Each cycle writes 0 to both RAMs at address 2^AWIDTH-N+p, for p=0..N-1. Then go to START.
- START/WAIT: `mm_start`=1 from START until `mm_done` is sampled high in WAIT.
- CLEAR: `mm_start`=0 and `mm_clear_done`=1 for exactly 1 cycle. Then go to RD_ADDR with k=0.
- RD_ADDR: drive `res_addr`=k for 1 cycle, then go to RD_DATA.
- RD_DATA: latch `res_rdata` into `out_data` and raise `out_valid`. Hold both until `out_ready`. Then k++, and either return to RD_ADDR or, after k=N*N-1, go to IDLE.
- `in_ready` is 0 outside the LOAD states. Stalls on `in_valid`=0 insert no writes.
- All counters are `$clog2(N*N)+1` bits. Address arithmetic is unsigned, truncated to AWIDTH.

## Timing
- Reset values: all outputs 0 except `cmd_ready`=1. State is IDLE, k=0, `error`=0.
- `reset` mid-job returns to IDLE on the next edge. Any pending RAM write and `mm_start` drop immediately, and no `mm_clear_done` is issued.
- A command accepted in IDLE gives `in_ready` on the next cycle.
- With full-rate input, the first `mm_start` occurs 2*N*N+N+1 cycles after command acceptance.
- `mm_done` already high on START entry is accepted in the first WAIT cycle.
- `cmd_valid` during `busy` is ignored (`cmd_ready`=0).
- Readout takes at least 2 cycles per element. `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `MATMUL_SEQ_WATCHDOG_EN` defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without `mm_done`, the block sets sticky `error`, drops `mm_start`, pulses `mm_clear_done`, and returns to IDLE with no readout. `error` clears only on `reset` or on the next accepted command.
- Not defined: WAIT has no bound, and `error` is tied to 0.

## Test plan
- Reset with `reset`=1 for 3 cycles, then release → all outputs 0, `cmd_ready`=1, `busy`=0.
- Full job with A={8,3,5,9,4,3,2,1,6,3,1,0,8,7,6,5} and B={1,1,3,0,0,1,4,3,3,5,3,1,9,6,3,2}, behavioural multiplier and RAMs → result stream begins 0x62,0x5A,0x52,0x22,0x4B. Addresses 32764..32767 of both RAMs read 0.
- Random `in_valid` gaps and `out_ready` backpressure → identical RAM contents and result stream; no duplicated or dropped bytes.
- Assert `reset` during WAIT → `mm_start`=0 on the next cycle, IDLE, and no `mm_clear_done` pulse.
- Hold `mm_done`=1 before START → exactly one START and one WAIT cycle, then a single `mm_clear_done` pulse.
- With `MATMUL_SEQ_WATCHDOG_EN` and TIMEOUT_CYCLES=16, hold `mm_done`=0 → `error`=1 after 16 WAIT cycles, `out_valid` never asserted, return to IDLE. A new command clears `error`.

Source files
------------

// File: rtl/matmul_seq_ctrl_if.sv
// Handshake, operand-RAM, result-RAM and multiplier-control bundle for matmul_seq_ctrl.
// The master side is the sequencer; the slave side is the host/RAM/multiplier environment.
interface matmul_seq_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 15
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              a_we;
  logic              b_we;
  logic [AWIDTH-1:0] a_addr;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] a_wdata;
  logic [DWIDTH-1:0] b_wdata;
  logic [AWIDTH-1:0] res_addr;
  logic [DWIDTH-1:0] res_rdata;
  logic              mm_start;
  logic              mm_clear_done;
  logic              mm_done;
  logic              busy;
  logic              error;

  modport master (
    input  cmd_valid, in_valid, in_data, out_ready, res_rdata, mm_done,
    output cmd_ready, in_ready, out_valid, out_data, a_we, b_we, a_addr, b_addr,
           a_wdata, b_wdata, res_addr, mm_start, mm_clear_done, busy, error
  );

  modport slave (
    output cmd_valid, in_valid, in_data, out_ready, res_rdata, mm_done,
    input  cmd_ready, in_ready, out_valid, out_data, a_we, b_we, a_addr, b_addr,
           a_wdata, b_wdata, res_addr, mm_start, mm_clear_done, busy, error
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for the NxN matrix multiplier: load A/B, zero the RAM tails, run, read back.
// Define MATMUL_SEQ_WATCHDOG_EN to bound the done-wait and enable the sticky error flag.
module matmul_seq_ctrl #(
  parameter int DWIDTH         = 8,
  parameter int AWIDTH         = 15,
  parameter int MAT_SIZE       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               reset,
  matmul_seq_ctrl_if.master bus
);
  localparam int NumElem = MAT_SIZE * MAT_SIZE;
  localparam int CntW    = $clog2(NumElem) + 1;
  localparam logic [CntW-1:0]   LastElem = CntW'(NumElem - 1);
  localparam logic [CntW-1:0]   LastPad  = CntW'(MAT_SIZE - 1);
  localparam logic [AWIDTH-1:0] PadBase  = AWIDTH'((2 ** AWIDTH) - MAT_SIZE);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, PAD, START, WAIT, CLEAR, RD_ADDR, RD_DATA
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   k_q, k_d;
  logic              held_q, held_d;
  logic [DWIDTH-1:0] data_q, data_d;

  logic              cmd_ready, in_ready, out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              a_we, b_we;
  logic [AWIDTH-1:0] a_addr, b_addr, res_addr;
  logic [DWIDTH-1:0] a_wdata, b_wdata;
  logic              mm_start, mm_clear_done;

`ifdef MATMUL_SEQ_WATCHDOG_EN
  localparam int WdtW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            error_q, error_d;
  logic            abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_q   <= '0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      error_q <= error_d;
      abort_q <= abort_d;
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      held_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      held_q  <= held_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    held_d        = held_q;
    data_d        = data_q;
    cmd_ready     = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    a_we          = 1'b0;
    b_we          = 1'b0;
    a_addr        = '0;
    b_addr        = '0;
    a_wdata       = '0;
    b_wdata       = '0;
    res_addr      = '0;
    mm_start      = 1'b0;
    mm_clear_done = 1'b0;
`ifdef MATMUL_SEQ_WATCHDOG_EN
    wdt_d         = '0;
    error_d       = error_q;
    abort_d       = abort_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_d = LOAD_A;
          k_d     = '0;
`ifdef MATMUL_SEQ_WATCHDOG_EN
          error_d = 1'b0;
`endif
        end
      end

      LOAD_A: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_we    = 1'b1;
          a_addr  = AWIDTH'(k_q);
          a_wdata = bus.in_data;
          if (k_q == LastElem) begin
            k_d     = '0;
            state_d = LOAD_B;
          end else begin
            k_d = k_q + CntW'(1);
          end
        end
      end

      LOAD_B: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          b_we    = 1'b1;
          b_addr  = AWIDTH'(k_q);
          b_wdata = bus.in_data;
          if (k_q == LastElem) begin
            k_d     = '0;
            state_d = PAD;
          end else begin
            k_d = k_q + CntW'(1);
          end
        end
      end

      // Zero the last N words of both RAMs; write data stays at its default of 0.
      PAD: begin
        a_we   = 1'b1;
        b_we   = 1'b1;
        a_addr = PadBase + AWIDTH'(k_q);
        b_addr = PadBase + AWIDTH'(k_q);
        if (k_q == LastPad) begin
          k_d     = '0;
          state_d = START;
        end else begin
          k_d = k_q + CntW'(1);
        end
      end

      START: begin
        mm_start = 1'b1;
        state_d  = WAIT;
      end

      WAIT: begin
        mm_start = 1'b1;
        if (bus.mm_done) begin
          state_d = CLEAR;
        end
`ifdef MATMUL_SEQ_WATCHDOG_EN
        else if (wdt_q == WdtW'(TIMEOUT_CYCLES - 1)) begin
          state_d = CLEAR;
          error_d = 1'b1;
          abort_d = 1'b1;
        end else begin
          wdt_d = wdt_q + WdtW'(1);
        end
`endif
      end

      CLEAR: begin
        mm_clear_done = 1'b1;
        k_d           = '0;
        state_d       = RD_ADDR;
`ifdef MATMUL_SEQ_WATCHDOG_EN
        if (abort_q) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end
`endif
      end

      RD_ADDR: begin
        res_addr = AWIDTH'(k_q);
        held_d   = 1'b0;
        state_d  = RD_DATA;
      end

      // The RAM only presents the word in the first RD_DATA cycle, so capture it for stalls.
      RD_DATA: begin
        out_valid = 1'b1;
        out_data  = held_q ? data_q : bus.res_rdata;
        if (!held_q) begin
          data_d = bus.res_rdata;
          held_d = 1'b1;
        end
        if (bus.out_ready) begin
          held_d = 1'b0;
          if (k_q == LastElem) begin
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d     = k_q + CntW'(1);
            state_d = RD_ADDR;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = out_data;
  assign bus.a_we          = a_we;
  assign bus.b_we          = b_we;
  assign bus.a_addr        = a_addr;
  assign bus.b_addr        = b_addr;
  assign bus.a_wdata       = a_wdata;
  assign bus.b_wdata       = b_wdata;
  assign bus.res_addr      = res_addr;
  assign bus.mm_start      = mm_start;
  assign bus.mm_clear_done = mm_clear_done;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: behavioural RAMs and multiplier, a
// write/result scoreboard checked every cycle, and directed job scenarios.
module tb_matmul_seq_ctrl;
  localparam int DW      = 8;
  localparam int AW      = 15;
  localparam int N       = 4;
  localparam int NN      = N * N;
  localparam int TO      = 16;
  localparam int PadBase = (1 << AW) - N;
  localparam int Never   = 1000000;

  typedef logic [7:0] mat_t [NN];
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  matmul_seq_ctrl #(
    .DWIDTH(DW), .AWIDTH(AW), .MAT_SIZE(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural environment: operand RAMs, 1-cycle result RAM and a multiplier
  // that computes C[i][j] = sum_k A[k*N+i] * B[k*N+j] and raises done after a latency.
  logic [7:0] ramA [0:(1<<AW)-1];
  logic [7:0] ramB [0:(1<<AW)-1];
  logic [7:0] resRam [0:NN-1];
  logic [7:0] resRdata = 8'h00;
  logic       doneReg = 1'b0;
  logic       forceDone = 1'b0;
  int         mmCnt = 0;
  int         doneLatency = 3;
  bit         randomReady = 1'b0;

  assign bus.mm_done   = forceDone | doneReg;
  assign bus.res_rdata = resRdata;

  function automatic logic [7:0] ramProduct(input int i, input int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(ramA[k*N+i]) * int'(ramB[k*N+j]);
    return 8'(s);
  endfunction

  always @(posedge clk) begin
    if (bus.a_we) ramA[bus.a_addr] <= bus.a_wdata;
    if (bus.b_we) ramB[bus.b_addr] <= bus.b_wdata;
    resRdata <= (int'(bus.res_addr) < NN) ? resRam[bus.res_addr[3:0]] : 8'hEE;
    if (reset || bus.mm_clear_done) begin
      doneReg <= 1'b0;
      mmCnt   <= 0;
    end else if (bus.mm_start) begin
      if (mmCnt == 0)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) resRam[i*N+j] <= ramProduct(i, j);
      mmCnt <= mmCnt + 1;
      if (mmCnt + 1 >= doneLatency) doneReg <= 1'b1;
    end else begin
      mmCnt <= 0;
    end
  end

  // Expectations built from the job vectors alone.
  wr_t        expA[$];
  wr_t        expB[$];
  logic [7:0] expOut[$];
  logic [7:0] got[$];

  task automatic pushJob(input mat_t A, input mat_t B, input bit withReadout);
    for (int k = 0; k < NN; k++) begin
      expA.push_back('{k, int'(A[k])});
      expB.push_back('{k, int'(B[k])});
    end
    for (int p = 0; p < N; p++) begin
      expA.push_back('{PadBase + p, 0});
      expB.push_back('{PadBase + p, 0});
    end
    if (withReadout)
      for (int idx = 0; idx < NN; idx++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(A[k*N + idx/N]) * int'(B[k*N + idx%N]);
        expOut.push_back(8'(s));
      end
  endtask

  // Compare process and event monitor, sampled mid-cycle.
  int         negCount = 0, acceptNeg = 0, firstInReadyNeg = 0, startNeg = -1, errorRiseNeg = 0;
  int         startCycles = 0, clearPulses = 0, aWrites = 0, bWrites = 0, outCount = 0;
  bit         sawInReady = 1'b0, prevStart = 1'b0, prevError = 1'b0, holdPending = 1'b0;
  logic [7:0] heldData = 8'h00;

  always @(negedge clk) begin
    wr_t e;
    negCount++;
    if (reset) begin
      holdPending = 1'b0;
      prevStart   = 1'b0;
      prevError   = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        acceptNeg  = negCount;
        sawInReady = 1'b0;
        startNeg   = -1;
      end
      if (bus.in_ready && !sawInReady) begin
        firstInReadyNeg = negCount;
        sawInReady      = 1'b1;
      end
      if (bus.mm_start) begin
        startCycles++;
        if (!prevStart && startNeg < 0) startNeg = negCount;
      end
      prevStart = bus.mm_start;
      if (bus.mm_clear_done) clearPulses++;
      if (bus.error && !prevError) errorRiseNeg = negCount;
      prevError = bus.error;

      if (bus.a_we) begin
        aWrites++;
        if (expA.size() == 0) checkOutput("a_write_unexpected_addr", bus.a_addr, -1);
        else begin
          e = expA.pop_front();
          checkOutput("a_addr", bus.a_addr, e.addr);
          checkOutput("a_wdata", bus.a_wdata, e.data);
        end
      end
      if (bus.b_we) begin
        bWrites++;
        if (expB.size() == 0) checkOutput("b_write_unexpected_addr", bus.b_addr, -1);
        else begin
          e = expB.pop_front();
          checkOutput("b_addr", bus.b_addr, e.addr);
          checkOutput("b_wdata", bus.b_wdata, e.data);
        end
      end

      if (holdPending) begin
        checkOutput("out_valid_hold", bus.out_valid, 1);
        checkOutput("out_data_hold", bus.out_data, heldData);
      end
      if (bus.out_valid && bus.out_ready) begin
        outCount++;
        got.push_back(bus.out_data);
        if (expOut.size() == 0) checkOutput("out_unexpected_data", bus.out_data, -1);
        else checkOutput("out_data", bus.out_data, expOut.pop_front());
      end
      holdPending = bus.out_valid && !bus.out_ready;
      heldData    = bus.out_data;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Issue one command and stream A then B, optionally with in_valid gaps and
  // with cmd_valid held high into the busy period.
  task automatic applyStimulus(input mat_t A, input mat_t B, input bit gaps, input bit holdCmd);
    int idx = 0;
    int guard = 0;
    bit acc;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!holdCmd) bus.cmd_valid = 1'b0;
    while (idx < 2*NN && guard < 2000) begin
      if (bus.cmd_valid) checkOutput("cmd_ready_while_busy", bus.cmd_ready, 0);
      if (guard == 3) bus.cmd_valid = 1'b0;
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = (idx < NN) ? A[idx] : B[idx-NN];
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    checkOutput("load_bytes_accepted", idx, 2*NN);
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < bound);
    checkOutput("job_returns_idle_busy", bus.busy, 0);
  endtask

  mat_t matA  = '{8,3,5,9, 4,3,2,1, 6,3,1,0, 8,7,6,5};
  mat_t matB  = '{1,1,3,0, 0,1,4,3, 3,5,3,1, 9,6,3,2};
  mat_t matB2 = '{2,0,0,1, 0,3,1,0, 7,0,0,2, 1,1,1,1};
  logic [7:0] pinned [5] = '{8'h62, 8'h5A, 8'h52, 8'h22, 8'h4B};

  initial begin
    int gotBase, aBase, bBase, clrBase, stBase, outBase, n;
    logic [7:0] job1 [NN];

    for (int i = 0; i < (1 << AW); i++) begin
      ramA[i] = 8'hFF;
      ramB[i] = 8'hFF;
    end
    for (int i = 0; i < NN; i++) resRam[i] = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_mm_start", bus.mm_start, 0);
    checkOutput("rst_mm_clear_done", bus.mm_clear_done, 0);
    checkOutput("rst_we", {bus.a_we, bus.b_we}, 0);
    checkOutput("rst_addr", {bus.a_addr, bus.b_addr, bus.res_addr}, 0);
    checkOutput("rst_error", bus.error, 0);

    // Job 1: full-rate input, no backpressure, command held while busy.
    $display("[TB] job 1: full-rate reference job");
    gotBase = got.size(); aBase = aWrites; bBase = bWrites; clrBase = clearPulses;
    pushJob(matA, matB, 1'b1);
    @(posedge clk); #1;
    applyStimulus(matA, matB, 1'b0, 1'b1);
    waitIdle(400);
    checkOutput("in_ready_latency", firstInReadyNeg - acceptNeg, 1);
    checkOutput("first_mm_start_latency", startNeg - acceptNeg, 2*NN + N + 1);
    checkOutput("job1_a_writes", aWrites - aBase, NN + N);
    checkOutput("job1_b_writes", bWrites - bBase, NN + N);
    checkOutput("job1_clear_pulses", clearPulses - clrBase, 1);
    checkOutput("job1_result_count", got.size() - gotBase, NN);
    for (int i = 0; i < 5; i++)
      if (gotBase + i < got.size()) checkOutput($sformatf("job1_pinned_c%0d", i), got[gotBase+i], pinned[i]);
    for (int i = 0; i < NN; i++) job1[i] = (gotBase + i < got.size()) ? got[gotBase+i] : 8'hXX;
    for (int k = 0; k < NN; k++) begin
      checkOutput($sformatf("ramA_%0d", k), ramA[k], matA[k]);
      checkOutput($sformatf("ramB_%0d", k), ramB[k], matB[k]);
    end
    for (int p = 0; p < N; p++) begin
      checkOutput($sformatf("ramA_pad_%0d", PadBase + p), ramA[PadBase+p], 0);
      checkOutput($sformatf("ramB_pad_%0d", PadBase + p), ramB[PadBase+p], 0);
    end
    checkOutput("job1_idle_cmd_ready", bus.cmd_ready, 1);

    // Job 2: same data with in_valid gaps and out_ready backpressure.
    $display("[TB] job 2: gaps and backpressure");
    gotBase = got.size(); aBase = aWrites; bBase = bWrites;
    randomReady = 1'b1;
    pushJob(matA, matB, 1'b1);
    applyStimulus(matA, matB, 1'b1, 1'b0);
    waitIdle(2000);
    randomReady = 1'b0;
    checkOutput("job2_a_writes", aWrites - aBase, NN + N);
    checkOutput("job2_b_writes", bWrites - bBase, NN + N);
    checkOutput("job2_result_count", got.size() - gotBase, NN);
    for (int i = 0; i < NN; i++)
      if (gotBase + i < got.size()) checkOutput($sformatf("job2_vs_job1_c%0d", i), got[gotBase+i], job1[i]);

    // Job 3: done already high before START, different B operand.
    $display("[TB] job 3: done held high before start");
    stBase = startCycles; clrBase = clearPulses; gotBase = got.size();
    forceDone = 1'b1;
    pushJob(matA, matB2, 1'b1);
    applyStimulus(matA, matB2, 1'b0, 1'b0);
    waitIdle(400);
    forceDone = 1'b0;
    checkOutput("early_done_start_cycles", startCycles - stBase, 2);
    checkOutput("early_done_clear_pulses", clearPulses - clrBase, 1);
    checkOutput("early_done_result_count", got.size() - gotBase, NN);

    // Job 4: reset while waiting for done.
    $display("[TB] job 4: reset during wait");
    doneLatency = Never;
    stBase = startCycles; outBase = outCount;
    pushJob(matB2, matA, 1'b0);
    applyStimulus(matB2, matA, 1'b0, 1'b0);
    n = 0;
    while (startCycles - stBase < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_wait", (startCycles - stBase) >= 3, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    clrBase = clearPulses;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_wait_mm_start", bus.mm_start, 0);
    checkOutput("rst_wait_busy", bus.busy, 0);
    checkOutput("rst_wait_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_wait_mm_clear_done", bus.mm_clear_done, 0);
    repeat (5) @(negedge clk);
    checkOutput("rst_wait_no_clear", clearPulses - clrBase, 0);
    checkOutput("rst_wait_no_output", outCount - outBase, 0);

`ifdef MATMUL_SEQ_WATCHDOG_EN
    // Job 5: done never arrives, watchdog aborts; job 6 clears the error.
    $display("[TB] job 5: watchdog timeout");
    stBase = startCycles; clrBase = clearPulses; outBase = outCount;
    pushJob(matA, matB, 1'b0);
    applyStimulus(matA, matB, 1'b0, 1'b0);
    waitIdle(200);
    checkOutput("wdt_error_set", bus.error, 1);
    checkOutput("wdt_error_rise_delay", errorRiseNeg - startNeg, TO + 1);
    checkOutput("wdt_start_cycles", startCycles - stBase, TO + 1);
    checkOutput("wdt_clear_pulses", clearPulses - clrBase, 1);
    checkOutput("wdt_no_output", outCount - outBase, 0);
    doneLatency = 3;
    gotBase = got.size();
    pushJob(matA, matB, 1'b1);
    applyStimulus(matA, matB, 1'b0, 1'b0);
    checkOutput("wdt_error_cleared", bus.error, 0);
    waitIdle(400);
    checkOutput("wdt_next_result_count", got.size() - gotBase, NN);
`endif

    checkOutput("leftover_expected_outputs", expOut.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] global timeout");
  end
endmodule
